registered_demultiplexer: RTL and testbench
===========================================

Name: registered_demultiplexer

Overview:
- 1-to-4 demultiplexer: inverse of the team's 4:1 multiplexer. Routes one input word, selected by addr0/addr1, to one of four output channels.
- Each output channel has a one-entry holding register with valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between a single producer and four independent consumers in the datapath.
- Includes a saturating count of accepted words for debug.

Parameters:
- WIDTH, 8, data width of input and each output channel.
- CNT_WIDTH, 8, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- addr0  input  1  select bit 0 (LSB).
- addr1  input  1  select bit 1 (MSB).
- in_data  input  WIDTH  input word.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block will accept the word this cycle.
- out0_data..out3_data  output  WIDTH each  channel holding-register contents.
- out0_valid..out3_valid  output  1 each  channel holds a word.
- out0_ready..out3_ready  input  1 each  consumer takes the word this cycle.
- accept_count  output  CNT_WIDTH  number of accepted input words, saturating.

Behaviour:
- Reset is synchronous, active-high, sampled on rising clk only.
- Reset values: all outN_valid=0, all outN_data=0, accept_count=0. in_ready follows its equation, so it reads 1 after reset.
- Channel select: sel = {addr1, addr0}. sel 0 -> out0, 1 -> out1, 2 -> out2, 3 -> out3. Matches the 4:1 mux addressing.
- in_ready (combinational) = !outSEL_valid || outSEL_ready.
  - The selected channel accepts when empty, or when it is full and draining in the same cycle.
- Accept: in_valid && in_ready at a rising edge. Next cycle:
  - outSEL_data = in_data.
  - outSEL_valid = 1.
  - accept_count increments.
- Drain: outN_valid && outN_ready at an edge. If channel N is not simultaneously being loaded, outN_valid goes to 0; outN_data holds its last value.
- Simultaneous drain and load on the same channel: load wins. valid stays 1 and data is replaced. Gives full throughput of 1 word/cycle per channel.
- Other channels are independent and unaffected by accepts on channel SEL.
- Latency: 1 cycle from accept to outN_valid=1.
- Data on a valid channel must not change until it is drained.
- addr and in_data may change freely while in_valid=0.
- A producer may change addr while in_valid=1 and not yet accepted. in_ready re-evaluates for the new channel; no ordering is enforced.
- accept_count saturates at 2^CNT_WIDTH-1 and does not wrap.
- Reset mid-operation: all buffered words are discarded, valids clear, counter clears, on the reset edge. An accept coincident with reset is dropped.
- No state machine beyond per-channel full/empty; four independent 2-state (EMPTY/FULL) channels.

Test Plan:
1. Reset -> all outN_valid=0, all outN_data=0, accept_count=0, in_ready=1.
2. Routing, one channel at a time, all outN_ready=0:
   - addr1=0, addr0=0, in_data=8'hA5, in_valid=1 for 1 cycle -> next cycle out0_valid=1, out0_data=A5, out1..3_valid=0, count=1.
   - Repeat for sel 1, 2, 3 with 8'h3C, 8'h0F, 8'hF0 -> each lands only on its channel, count=4.
3. Backpressure:
   - Channel 2 full, out2_ready=0, sel=2, in_valid=1 -> in_ready=0, out2_data unchanged, count unchanged.
   - Switch to sel=1 with out1 empty -> in_ready=1.
4. Pass-through:
   - out3 full with 8'h11, out3_ready=1, sel=3, in_data=8'h22, in_valid=1 -> in_ready=1.
   - Next cycle out3_valid=1, out3_data=22.
   - Stream 10 consecutive words -> all 10 received in order, no bubbles.
5. Saturation:
   - CNT_WIDTH=4, 20 accepts with consumers always ready -> accept_count stops at 15.
6. Reset mid-operation:
   - Channels 0 and 2 full, assert reset for 1 cycle with in_valid=1 -> all valids 0, count 0.
   - After deassert, one accept -> count=1.

Source files
------------

// File: rtl/registered_demultiplexer.sv
// 1-to-4 demultiplexer with a one-entry valid/ready holding register per output channel
// and a saturating count of accepted input words.
module registered_demultiplexer #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 addr0,
    input  logic                 addr1,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out0_data,
    output logic [WIDTH-1:0]     out1_data,
    output logic [WIDTH-1:0]     out2_data,
    output logic [WIDTH-1:0]     out3_data,
    output logic                 out0_valid,
    output logic                 out1_valid,
    output logic                 out2_valid,
    output logic                 out3_valid,
    input  logic                 out0_ready,
    input  logic                 out1_ready,
    input  logic                 out2_ready,
    input  logic                 out3_ready,
    output logic [CNT_WIDTH-1:0] accept_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           sel;
    logic [3:0]           ready_vec;
    logic                 accept;
    logic [3:0]           valid_q, valid_d;
    logic [WIDTH-1:0]     data_q [4];
    logic [WIDTH-1:0]     data_d [4];
    logic [CNT_WIDTH-1:0] count_q, count_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign sel       = {addr1, addr0};
    assign ready_vec = {out3_ready, out2_ready, out1_ready, out0_ready};

    // A full channel can still accept when its consumer drains it in the same cycle.
    assign in_ready = !valid_q[sel] || ready_vec[sel];
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q & ~ready_vec;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = data_q[i];
        end
        count_d = count_q;
        if (accept) begin
            valid_d[sel] = 1'b1;
            data_d[sel]  = in_data;
            count_d      = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out0_data    = data_q[0];
    assign out1_data    = data_q[1];
    assign out2_data    = data_q[2];
    assign out3_data    = data_q[3];
    assign out0_valid   = valid_q[0];
    assign out1_valid   = valid_q[1];
    assign out2_valid   = valid_q[2];
    assign out3_valid   = valid_q[3];
    assign accept_count = count_q;

endmodule

// File: tb/tb_registered_demultiplexer.sv
// Directed bench for registered_demultiplexer: a behavioural channel model checked every
// cycle, plus literal expectations; a second instance with a 4-bit counter shows saturation.
module tb_registered_demultiplexer;

    logic       clk = 1'b0;
    logic       reset;
    logic       addr0, addr1;
    logic [7:0] in_data;
    logic       in_valid;
    logic [3:0] rdy;

    logic       a_in_ready, b_in_ready;
    logic [7:0] a_d0, a_d1, a_d2, a_d3, b_d0, b_d1, b_d2, b_d3;
    logic       a_v0, a_v1, a_v2, a_v3, b_v0, b_v1, b_v2, b_v3;
    logic [7:0] a_cnt;
    logic [3:0] b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    registered_demultiplexer #(.WIDTH(8), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1),
        .in_data(in_data), .in_valid(in_valid), .in_ready(a_in_ready),
        .out0_data(a_d0), .out1_data(a_d1), .out2_data(a_d2), .out3_data(a_d3),
        .out0_valid(a_v0), .out1_valid(a_v1), .out2_valid(a_v2), .out3_valid(a_v3),
        .out0_ready(rdy[0]), .out1_ready(rdy[1]), .out2_ready(rdy[2]), .out3_ready(rdy[3]),
        .accept_count(a_cnt)
    );

    registered_demultiplexer #(.WIDTH(8), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .addr0(addr0), .addr1(addr1),
        .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
        .out0_data(b_d0), .out1_data(b_d1), .out2_data(b_d2), .out3_data(b_d3),
        .out0_valid(b_v0), .out1_valid(b_v1), .out2_valid(b_v2), .out3_valid(b_v3),
        .out0_ready(rdy[0]), .out1_ready(rdy[1]), .out2_ready(rdy[2]), .out3_ready(rdy[3]),
        .accept_count(b_cnt)
    );

    logic [3:0] av, bv;
    logic [7:0] ad [4];
    logic [7:0] bd [4];
    assign av = {a_v3, a_v2, a_v1, a_v0};
    assign bv = {b_v3, b_v2, b_v1, b_v0};
    assign ad[0] = a_d0;
    assign ad[1] = a_d1;
    assign ad[2] = a_d2;
    assign ad[3] = a_d3;
    assign bd[0] = b_d0;
    assign bd[1] = b_d1;
    assign bd[2] = b_d2;
    assign bd[3] = b_d3;

    // Behavioural model: each channel is a one-word box; a word goes into the box addressed
    // by the producer whenever that box is empty or being emptied this cycle.
    logic [3:0] m_full;
    logic [7:0] m_word [4];
    int         m_cnt8, m_cnt4;
    bit         m_known = 1'b0;

    function automatic bit m_can_take();
        int s;
        s = addr1 * 2 + addr0;
        return (m_full[s] == 1'b0) || (rdy[s] == 1'b1);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_known <= 1'b1;
            m_full  <= 4'b0000;
            m_cnt8  <= 0;
            m_cnt4  <= 0;
            for (int n = 0; n < 4; n++) m_word[n] <= 8'h00;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (m_full[n] && rdy[n]) m_full[n] <= 1'b0;
            end
            if (in_valid && m_can_take()) begin
                m_full[addr1 * 2 + addr0] <= 1'b1;
                m_word[addr1 * 2 + addr0] <= in_data;
                m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt4 <= (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (m_known) begin
            check("model in_ready A", int'(a_in_ready), int'(m_can_take()));
            check("model in_ready B", int'(b_in_ready), int'(m_can_take()));
            check("model valids A", int'(av), int'(m_full));
            check("model valids B", int'(bv), int'(m_full));
            for (int n = 0; n < 4; n++) begin
                check("model data A", int'(ad[n]), int'(m_word[n]));
                check("model data B", int'(bd[n]), int'(m_word[n]));
            end
            check("model count A", int'(a_cnt), m_cnt8);
            check("model count B", int'(b_cnt), m_cnt4);
        end
    end

    task automatic edge_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int s, input logic [7:0] d, input logic v);
        addr1    = s[1];
        addr0    = s[0];
        in_data  = d;
        in_valid = v;
    endtask

    initial begin
        logic [7:0] route_data [4];
        route_data[0] = 8'hA5;
        route_data[1] = 8'h3C;
        route_data[2] = 8'h0F;
        route_data[3] = 8'hF0;

        reset = 1'b1;
        rdy   = 4'b0000;
        drive(0, 8'h00, 1'b0);
        edge_tick();
        edge_tick();
        reset = 1'b0;
        #1;
        check("reset valids", int'(av), 0);
        check("reset data0", int'(a_d0), 0);
        check("reset data3", int'(a_d3), 0);
        check("reset count", int'(a_cnt), 0);
        check("reset in_ready", int'(a_in_ready), 1);

        // Routing, one channel at a time, consumers stalled
        for (int k = 0; k < 4; k++) begin
            drive(k, route_data[k], 1'b1);
            edge_tick();
            drive(k, 8'h00, 1'b0);
            check("route valid", int'(av), (1 << (k + 1)) - 1);
            check("route data", int'(ad[k]), int'(route_data[k]));
            check("route count", int'(a_cnt), k + 1);
        end

        // Drain channel 1; data is held after the valid drops
        rdy = 4'b0010;
        edge_tick();
        rdy = 4'b0000;
        check("drain valid1", int'(a_v1), 0);
        check("drain data1 held", int'(a_d1), 8'h3C);

        // Backpressure on full channel 2
        drive(2, 8'h55, 1'b1);
        #1;
        check("bp in_ready", int'(a_in_ready), 0);
        edge_tick();
        check("bp data2", int'(a_d2), 8'h0F);
        check("bp count", int'(a_cnt), 4);
        drive(1, 8'h66, 1'b1);
        #1;
        check("bp switch in_ready", int'(a_in_ready), 1);
        edge_tick();
        drive(0, 8'h00, 1'b0);
        check("switch data1", int'(a_d1), 8'h66);
        check("switch count", int'(a_cnt), 5);

        // Pass-through on channel 3: replace F0 with 11, then 22, then stream
        rdy = 4'b1000;
        drive(3, 8'h11, 1'b1);
        edge_tick();
        check("pt data 11", int'(a_d3), 8'h11);
        drive(3, 8'h22, 1'b1);
        #1;
        check("pt in_ready", int'(a_in_ready), 1);
        edge_tick();
        check("pt valid3", int'(a_v3), 1);
        check("pt data 22", int'(a_d3), 8'h22);
        for (int i = 0; i < 10; i++) begin
            drive(3, 8'h30 + 8'(i), 1'b1);
            edge_tick();
            check("stream valid3", int'(a_v3), 1);
            check("stream data3", int'(a_d3), 8'h30 + i);
        end
        drive(0, 8'h00, 1'b0);
        check("stream count A", int'(a_cnt), 17);
        check("stream count B sat", int'(b_cnt), 15);

        // Saturation from a clean start
        reset = 1'b1;
        edge_tick();
        reset = 1'b0;
        rdy = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            drive(0, 8'(i), 1'b1);
            edge_tick();
            check("sat count B", int'(b_cnt), (i + 1 < 15) ? i + 1 : 15);
        end
        drive(0, 8'h00, 1'b0);
        check("sat count A", int'(a_cnt), 20);
        check("sat count B final", int'(b_cnt), 15);

        // Reset mid-operation with a coincident accept
        rdy = 4'b0000;
        edge_tick();
        drive(0, 8'hC0, 1'b1);
        edge_tick();
        drive(2, 8'hC2, 1'b1);
        edge_tick();
        check("pre-reset valids", int'(av), 4'b0101);
        reset = 1'b1;
        drive(1, 8'hEE, 1'b1);
        edge_tick();
        reset = 1'b0;
        drive(0, 8'h00, 1'b0);
        check("mid reset valids", int'(av), 0);
        check("mid reset count", int'(a_cnt), 0);
        check("mid reset data1", int'(a_d1), 0);
        drive(2, 8'h77, 1'b1);
        edge_tick();
        drive(0, 8'h00, 1'b0);
        check("post reset count", int'(a_cnt), 1);
        check("post reset data2", int'(a_d2), 8'h77);

        edge_tick();
        edge_tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
